// File: rtl/lcd_frame_seq.sv
// Frame-buffer sequencer for an HD44780 16x2 LCD: power-up delay, init commands, then full-frame refreshes.
// Optional build macro LCD_FRAME_SEQ_AUTOREFRESH_EN: buffer writes also request a refresh.
module lcd_frame_seq #(
    parameter int POWERUP_CYCLES = 1000000,
    parameter int WAIT_TIMEOUT   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       refresh,
    input  logic       cmd_ready,
    output logic [7:0] cmd_data,
    output logic       cmd_regsel,
    output logic       cmd_activate,
    output logic       busy,
    output logic       init_done
);
    localparam int PW = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
    localparam int TW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [PW-1:0] PWR_LAST = PW'(POWERUP_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(WAIT_TIMEOUT - 1);
    localparam logic PH_INIT  = 1'b0;
    localparam logic PH_FRAME = 1'b1;

    typedef enum logic [2:0] {
        PWRUP,
        ISSUE,
        WAIT_LO,
        WAIT_HI,
        NEXT,
        IDLE
    } state_t;

    state_t        state_q, state_d;
    logic          phase_q, phase_d;
    logic [5:0]    step_q, step_d;
    logic [PW-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          pending_q, pending_d;
    logic          init_done_q, init_done_d;
    logic          busy_q, busy_d;
    logic [7:0]    cmd_data_q, cmd_data_d;
    logic          cmd_regsel_q, cmd_regsel_d;
    logic          cmd_activate_q, cmd_activate_d;
    logic [7:0]    fbuf_q [32];
    logic [7:0]    fbuf_d [32];

    logic [7:0]    seq_data;
    logic          seq_regsel;
    logic          seq_last;
    logic [4:0]    buf_idx;
    logic          set_pending;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction

    // Byte to send for the current phase/step; buffer bytes are looked up live so late writes land.
    always_comb begin
        seq_data   = 8'h00;
        seq_regsel = 1'b0;
        seq_last   = 1'b0;
        buf_idx    = step_q[4:0] - ((step_q <= 6'd17) ? 5'd1 : 5'd2);
        if (phase_q == PH_INIT) begin
            seq_data = init_cmd(step_q[1:0]);
            seq_last = (step_q == 6'd3);
        end else begin
            seq_last = (step_q == 6'd33);
            if (step_q == 6'd0) begin
                seq_data = 8'h80;
            end else if (step_q == 6'd17) begin
                seq_data = 8'hC0;
            end else begin
                seq_data   = fbuf_q[buf_idx];
                seq_regsel = 1'b1;
            end
        end
    end

    always_comb begin
`ifdef LCD_FRAME_SEQ_AUTOREFRESH_EN
        set_pending = refresh | wr_en;
`else
        set_pending = refresh;
`endif
    end

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        step_d         = step_q;
        pwr_cnt_d      = pwr_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        pending_d      = pending_q;
        init_done_d    = init_done_q;
        cmd_data_d     = cmd_data_q;
        cmd_regsel_d   = cmd_regsel_q;
        cmd_activate_d = 1'b0;
        fbuf_d         = fbuf_q;

        if (wr_en) begin
            fbuf_d[wr_addr] = wr_data;
        end

        case (state_q)
            PWRUP: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    pwr_cnt_d = '0;
                    phase_d   = PH_INIT;
                    step_d    = 6'd0;
                    state_d   = ISSUE;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    cmd_data_d     = seq_data;
                    cmd_regsel_d   = seq_regsel;
                    cmd_activate_d = 1'b1;
                    tmo_cnt_d      = '0;
                    state_d        = WAIT_LO;
                end
            end
            WAIT_LO: begin
                // A consumer that never drops ready missed the strobe; resend the same step.
                if (!cmd_ready) begin
                    state_d = WAIT_HI;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ISSUE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            WAIT_HI: begin
                if (cmd_ready) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (seq_last) begin
                    if (phase_q == PH_INIT) begin
                        init_done_d = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    step_d  = step_q + 6'd1;
                    state_d = ISSUE;
                end
            end
            IDLE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    phase_d   = PH_FRAME;
                    step_d    = 6'd0;
                    state_d   = ISSUE;
                end
            end
            default: state_d = PWRUP;
        endcase

        // A new request in the same cycle IDLE consumes the old one must survive.
        if (set_pending) begin
            pending_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= PWRUP;
            phase_q        <= PH_INIT;
            step_q         <= 6'd0;
            pwr_cnt_q      <= '0;
            tmo_cnt_q      <= '0;
            pending_q      <= 1'b0;
            init_done_q    <= 1'b0;
            busy_q         <= 1'b1;
            cmd_data_q     <= 8'h00;
            cmd_regsel_q   <= 1'b0;
            cmd_activate_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                fbuf_q[i] <= 8'h20;
            end
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            step_q         <= step_d;
            pwr_cnt_q      <= pwr_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            pending_q      <= pending_d;
            init_done_q    <= init_done_d;
            busy_q         <= busy_d;
            cmd_data_q     <= cmd_data_d;
            cmd_regsel_q   <= cmd_regsel_d;
            cmd_activate_q <= cmd_activate_d;
            fbuf_q         <= fbuf_d;
        end
    end

    assign cmd_data     = cmd_data_q;
    assign cmd_regsel   = cmd_regsel_q;
    assign cmd_activate = cmd_activate_q;
    assign busy         = busy_q;
    assign init_done    = init_done_q;

endmodule

// File: tb/tb_lcd_frame_seq.sv
// Scoreboard bench for lcd_frame_seq with a behavioural lcd_ctrl responder and a frame-level reference model.
module tb_lcd_frame_seq;
    localparam int PWR  = 10;
    localparam int XFER = 20;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       refresh;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       cmd_regsel;
    logic       cmd_activate;
    logic       busy;
    logic       init_done;

    typedef struct packed {
        logic       rs;
        logic [7:0] d;
    } xfer_t;

    xfer_t      exp_q[$];
    logic [7:0] shadow [32];
    int         checks;
    int         failures;
    int         act_seen;
    int         drop_req;
    int         drop_done;

    lcd_frame_seq #(
        .POWERUP_CYCLES(PWR),
        .WAIT_TIMEOUT  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .refresh     (refresh),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .cmd_regsel  (cmd_regsel),
        .cmd_activate(cmd_activate),
        .busy        (busy),
        .init_done   (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    // Responder: busy for XFER cycles per accepted strobe; can be told to ignore strobes.
    initial begin : ctrl_model
        int busy_cnt;
        busy_cnt  = 0;
        drop_done = 0;
        cmd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                cmd_ready = 1'b1;
                busy_cnt  = 0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) cmd_ready = 1'b1;
            end else if (cmd_activate && cmd_ready) begin
                if (drop_done != drop_req) begin
                    drop_done++;
                end else begin
                    cmd_ready = 1'b0;
                    busy_cnt  = XFER;
                end
            end
        end
    end

    initial begin : monitor
        logic  last_act;
        xfer_t e;
        last_act = 1'b0;
        act_seen = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                exp_q.delete();
                last_act = 1'b0;
            end else begin
                if (cmd_activate) begin
                    check("act_gap", 32'(last_act), 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_act actual=%0h/%0h expected=none", cmd_regsel, cmd_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("xfer", {23'd0, cmd_regsel, cmd_data}, {23'd0, e.rs, e.d});
                    end
                    act_seen++;
                end
                last_act = cmd_activate;
            end
        end
    end

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    task automatic push_frame();
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, shadow[i]});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, shadow[i]});
    endtask

    task automatic write_byte(input logic [4:0] a, input logic [7:0] d);
        shadow[a] = d;
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_refresh();
        @(negedge clk);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 32'(n < 5000), 32'd1);
        repeat (30) @(negedge clk);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_act(input int target, input string name);
        int n;
        n = 0;
        while (act_seen < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 32'(n < 3000), 32'd1);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_data"}, 32'(cmd_data), 32'h00);
        check({name, "_regsel"}, 32'(cmd_regsel), 32'd0);
        check({name, "_act"}, 32'(cmd_activate), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd1);
        check({name, "_init_done"}, 32'(init_done), 32'd0);
    endtask

    task automatic pwrup_quiet(input string name);
        for (int i = 0; i < PWR; i++) begin
            @(negedge clk);
            check({name, "_quiet"}, 32'(cmd_activate), 32'd0);
        end
    endtask

    task automatic check_no_auto(input string name);
        int a0;
        a0 = act_seen;
        repeat (40) @(negedge clk);
        check({name, "_no_act"}, 32'(act_seen - a0), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int         base;
        int         nw;
        logic [7:0] d;
        checks   = 0;
        failures = 0;
        drop_req = 0;
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = 8'h00;
        refresh  = 1'b0;
        for (int i = 0; i < 32; i++) shadow[i] = 8'h20;

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        push_init();
        pwrup_quiet("por");
        wait_idle("init");
        check("init_done", 32'(init_done), 32'd1);

        // Single write at address 5.
        write_byte(5'd5, 8'h41);
`ifdef LCD_FRAME_SEQ_AUTOREFRESH_EN
        push_frame();
`else
        check_no_auto("single");
        push_frame();
        pulse_refresh();
`endif
        wait_idle("single");

        // Randomized batches of writes.
        for (int r = 0; r < 3; r++) begin
            nw = $urandom_range(1, 3);
`ifdef LCD_FRAME_SEQ_AUTOREFRESH_EN
            for (int k = 0; k < nw; k++) begin
                write_byte(5'($urandom_range(0, 31)), 8'($urandom_range(33, 126)));
                push_frame();
                wait_idle("rand_auto");
            end
`else
            for (int k = 0; k < nw; k++) begin
                write_byte(5'($urandom_range(0, 31)), 8'($urandom_range(33, 126)));
            end
            check_no_auto("rand");
            push_frame();
            pulse_refresh();
            wait_idle("rand");
`endif
        end

        // Write the last byte and re-request while a frame is at step 10.
        base = act_seen;
        push_frame();
        pulse_refresh();
        wait_act(base + 11, "mid_step");
        d = 8'h5A;
        @(negedge clk);
        wr_en      = 1'b1;
        wr_addr    = 5'd31;
        wr_data    = d;
        refresh    = 1'b1;
        shadow[31] = d;
        exp_q[$]   = {1'b1, d};
        @(negedge clk);
        wr_en   = 1'b0;
        refresh = 1'b0;
        push_frame();
        wait_idle("mid_write");

        // First strobe of the frame is ignored; expect 0x80 to be resent.
        drop_req++;
        exp_q.push_back({1'b0, 8'h80});
        push_frame();
        pulse_refresh();
        wait_idle("lost_hs");
        check("lost_hs_dropped", 32'(drop_done), 32'(drop_req));

        // Reset while a frame is at step 20.
        base = act_seen;
        push_frame();
        pulse_refresh();
        wait_act(base + 21, "rst_step");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_vals("mid_reset");
        for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        push_init();
        pwrup_quiet("rerun");
        wait_idle("reinit");
        check("reinit_done", 32'(init_done), 32'd1);
        push_frame();
        pulse_refresh();
        wait_idle("blank_frame");

        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
